// File: rtl/panda_imem_resp_if.sv
// Fetch request/response bus between the PC stage (master) and the instruction memory (slave),
// plus the fill port used to load the memory.
interface panda_imem_resp_if #(
  parameter int unsigned Width = 32
);
  logic             req;
  logic [Width-1:0] addr;
  logic             gnt;
  logic             flush;
  logic             rvalid;
  logic [31:0]      rdata;
  logic             err;
  logic             we;
  logic [Width-1:0] waddr;
  logic [31:0]      wdata;

  modport master (
    output req, addr, flush, we, waddr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, flush, we, waddr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/panda_imem_resp.sv
// Instruction-memory responder: fixed-latency, in-order fetch pipeline with a bounded number of
// in-flight fetches, flush support and a write-only fill port.
module panda_imem_resp #(
  parameter int unsigned Width          = 32,
  parameter int unsigned Depth          = 256,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  panda_imem_resp_if.slave   bus
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [31:0]        mem [Depth];
  logic [Aw-1:0]      ridx;
  logic [Aw-1:0]      widx;
  logic               rd_err;
  logic               w_in_range;
  logic               gnt;
  int unsigned        inflight;
  int unsigned        pending;

  logic [Latency-1:0] valid_q;
  logic [Latency-1:0] err_q;
  logic [31:0]        data_q [Latency];

  logic               unused_waddr;
  assign unused_waddr = ^bus.waddr[1:0];

  assign ridx       = bus.addr[Aw+1:2];
  assign widx       = bus.waddr[Aw+1:2];
  assign rd_err     = (bus.addr[1:0] != 2'b00) || (bus.addr[Width-1:Aw+2] != '0);
  assign w_in_range = (bus.waddr[Width-1:Aw+2] == '0);

  // The last stage retires this cycle, so its slot is free for a new grant.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < int'(Latency); i++) begin
      inflight = inflight + 32'(valid_q[i]);
    end
    pending = inflight - 32'(valid_q[Latency-1]);
  end

  assign gnt     = bus.req && (pending < MaxOutstanding);
  assign bus.gnt = gnt;

  // Read-first: stage 0 samples the old word before a same-cycle write lands.
  always_ff @(posedge clk_i) begin
    if (bus.we && w_in_range) begin
      mem[widx] <= bus.wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < int'(Latency); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      // A grant in the flush cycle belongs to the new flow and survives.
      valid_q[0] <= gnt;
      err_q[0]   <= rd_err;
      data_q[0]  <= rd_err ? 32'h0 : mem[ridx];
      for (int i = 1; i < int'(Latency); i++) begin
        valid_q[i] <= valid_q[i-1] & ~bus.flush;
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign bus.rvalid = valid_q[Latency-1];
  assign bus.err    = err_q[Latency-1];
  assign bus.rdata  = data_q[Latency-1];

endmodule
